// File: rtl/pll_mgmt_responder.sv
// PLL management responder: memory-mapped shadow settings plus a sequencer that
// applies them, pulses pll_areset and waits (with timeout) for the PLL to relock.
module pll_mgmt_responder #(
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic        mgmt_clk,
  input  logic        mgmt_reset,
  input  logic [5:0]  mgmt_address,
  input  logic        mgmt_write,
  input  logic [31:0] mgmt_writedata,
  input  logic        mgmt_read,
  output logic [31:0] mgmt_readdata,
  output logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        pll_areset,
  output logic [31:0] cfg_n,
  output logic [31:0] cfg_m,
  output logic [31:0] cfg_c0,
  output logic [31:0] cfg_frac,
  output logic        reconf_done
);

  localparam int MAX_CNT = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  localparam logic [31:0] N_DEF    = 32'h0001_0000;
  localparam logic [31:0] M_DEF    = 32'h0000_0404;
  localparam logic [31:0] C0_DEF   = 32'h0000_0505;
  localparam logic [31:0] FRAC_DEF = 32'h9745_BF27;

  typedef enum logic [2:0] {IDLE, APPLY, RST, LOCKWAIT, DONE} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mode_q, err_q, areset_q, done_q;
  logic [31:0]      shN_q, shM_q, shC0_q, shFrac_q;
  logic [31:0]      cfgN_q, cfgM_q, cfgC0_q, cfgFrac_q;
  logic [31:0]      rdata_q, rdata_d;
  logic             busy, wrAcc, rdAcc, ctrlWr;

  assign busy             = (state_q != IDLE);
  assign mgmt_waitrequest = ~mode_q & busy;
  assign wrAcc            = mgmt_write & ~mgmt_waitrequest;
  assign rdAcc            = mgmt_read & ~mgmt_waitrequest;
  // MODE, STATUS and START are only writable while idle; shadows always are.
  assign ctrlWr           = wrAcc & ~busy;

  assign mgmt_readdata = rdata_q;
  assign pll_areset    = areset_q;
  assign reconf_done   = done_q;
  assign cfg_n         = cfgN_q;
  assign cfg_m         = cfgM_q;
  assign cfg_c0        = cfgC0_q;
  assign cfg_frac      = cfgFrac_q;

  always_comb begin
    rdata_d = rdata_q;
    if (rdAcc) begin
      case (mgmt_address)
        6'd0:    rdata_d = {31'd0, mode_q};
        6'd1:    rdata_d = {29'd0, pll_locked, err_q, busy};
        6'd3:    rdata_d = shN_q;
        6'd4:    rdata_d = shM_q;
        6'd5:    rdata_d = shC0_q;
        6'd7:    rdata_d = shFrac_q;
        default: rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge mgmt_clk) begin
    if (mgmt_reset) rdata_q <= 32'd0;
    else            rdata_q <= rdata_d;
  end

  always_ff @(posedge mgmt_clk) begin
    if (mgmt_reset) begin
      shN_q    <= N_DEF;
      shM_q    <= M_DEF;
      shC0_q   <= C0_DEF;
      shFrac_q <= FRAC_DEF;
    end else if (wrAcc) begin
      case (mgmt_address)
        6'd3: shN_q <= mgmt_writedata;
        6'd4: shM_q <= mgmt_writedata;
        6'd5: if (mgmt_writedata[22:18] == 5'd0) shC0_q <= mgmt_writedata;
        6'd7: shFrac_q <= mgmt_writedata;
        default: ;
      endcase
    end
  end

  // cfg_* are loaded on the edge into APPLY so the new values are visible for the whole APPLY cycle.
  always_ff @(posedge mgmt_clk) begin
    if (mgmt_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      areset_q  <= 1'b0;
      done_q    <= 1'b0;
      mode_q    <= 1'b0;
      err_q     <= 1'b0;
      cfgN_q    <= N_DEF;
      cfgM_q    <= M_DEF;
      cfgC0_q   <= C0_DEF;
      cfgFrac_q <= FRAC_DEF;
    end else begin
      if (ctrlWr && mgmt_address == 6'd0) mode_q <= mgmt_writedata[0];
      if (ctrlWr && mgmt_address == 6'd1) err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ctrlWr && mgmt_address == 6'd2) begin
            state_q   <= APPLY;
            cfgN_q    <= shN_q;
            cfgM_q    <= shM_q;
            cfgC0_q   <= shC0_q;
            cfgFrac_q <= shFrac_q;
          end
        end
        APPLY: begin
          state_q  <= RST;
          areset_q <= 1'b1;
          cnt_q    <= '0;
        end
        RST: begin
          if (cnt_q == RST_LAST) begin
            state_q  <= LOCKWAIT;
            areset_q <= 1'b0;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        LOCKWAIT: begin
          if (pll_locked) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (cnt_q == LOCK_LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_mgmt_responder.sv
// Self-checking bench for pll_mgmt_responder: register table vectors plus
// hand-written reconfiguration, stall, timeout, polling and reset sequences.
module tb_pll_mgmt_responder;

  logic        mgmt_clk = 1'b0;
  logic        mgmt_reset;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_read;
  logic [31:0] mgmt_readdata;
  logic        mgmt_waitrequest;
  logic        pll_locked;
  logic        pll_areset;
  logic [31:0] cfg_n, cfg_m, cfg_c0, cfg_frac;
  logic        reconf_done;

  int checks = 0;
  int failures = 0;
  logic [31:0] expQ[$];

  typedef struct {
    bit          wr;
    bit          rd;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] expRd;
  } vec_t;
  vec_t vecs[20];

  int  arCycles, doneCnt, stallBad, sinceFall, stalled, doneCycle;
  bit  prevAr, sawDone, sawIdle, sawAreset;

  pll_mgmt_responder #(.RESET_CYCLES(16), .LOCK_TIMEOUT(4096)) dut (
    .mgmt_clk(mgmt_clk), .mgmt_reset(mgmt_reset), .mgmt_address(mgmt_address),
    .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata), .mgmt_read(mgmt_read),
    .mgmt_readdata(mgmt_readdata), .mgmt_waitrequest(mgmt_waitrequest),
    .pll_locked(pll_locked), .pll_areset(pll_areset), .cfg_n(cfg_n), .cfg_m(cfg_m),
    .cfg_c0(cfg_c0), .cfg_frac(cfg_frac), .reconf_done(reconf_done)
  );

  always #5 mgmt_clk = ~mgmt_clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One bus cycle issued at a falling edge; read expectations go through the scoreboard queue.
  task automatic applyStimulus(input bit wr, input bit rd, input logic [5:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expRd, input string name);
    @(negedge mgmt_clk);
    mgmt_write     = wr;
    mgmt_read      = rd;
    mgmt_address   = addr;
    mgmt_writedata = wdata;
    if (rd) expQ.push_back(expRd);
    @(posedge mgmt_clk);
    @(negedge mgmt_clk);
    mgmt_write = 1'b0;
    mgmt_read  = 1'b0;
    if (rd) checkOutput(name, mgmt_readdata, expQ.pop_front());
  endtask

  task automatic startReconf();
    @(negedge mgmt_clk);
    mgmt_write     = 1'b1;
    mgmt_address   = 6'd2;
    mgmt_writedata = 32'h1;
    @(posedge mgmt_clk);
    #1;
    mgmt_write = 1'b0;
  endtask

  initial begin
    mgmt_reset = 1'b1; mgmt_address = '0; mgmt_write = 1'b0; mgmt_writedata = '0;
    mgmt_read = 1'b0; pll_locked = 1'b0;
    repeat (3) @(posedge mgmt_clk);
    @(negedge mgmt_clk);
    mgmt_reset = 1'b0;
    checkOutput("rst_readdata", mgmt_readdata, 32'h0);
    checkOutput("rst_waitrequest", mgmt_waitrequest, 32'h0);
    checkOutput("rst_areset", pll_areset, 32'h0);
    checkOutput("rst_done", reconf_done, 32'h0);
    checkOutput("rst_cfg_n", cfg_n, 32'h0001_0000);
    checkOutput("rst_cfg_m", cfg_m, 32'h0000_0404);
    checkOutput("rst_cfg_c0", cfg_c0, 32'h0000_0505);
    checkOutput("rst_cfg_frac", cfg_frac, 32'h9745_BF27);

    vecs[0]  = '{1'b0, 1'b1, 6'd3,  32'h0,         32'h0001_0000};
    vecs[1]  = '{1'b0, 1'b1, 6'd4,  32'h0,         32'h0000_0404};
    vecs[2]  = '{1'b0, 1'b1, 6'd5,  32'h0,         32'h0000_0505};
    vecs[3]  = '{1'b0, 1'b1, 6'd7,  32'h0,         32'h9745_BF27};
    vecs[4]  = '{1'b0, 1'b1, 6'd0,  32'h0,         32'h0};
    vecs[5]  = '{1'b0, 1'b1, 6'd1,  32'h0,         32'h0};
    vecs[6]  = '{1'b1, 1'b0, 6'd6,  32'hDEAD_BEEF, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 6'd6,  32'h0,         32'h0};
    vecs[8]  = '{1'b1, 1'b0, 6'd5,  32'h00FC_0001, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 6'd5,  32'h0,         32'h0000_0505};
    vecs[10] = '{1'b1, 1'b0, 6'd5,  32'h0003_0506, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 6'd5,  32'h0,         32'h0003_0506};
    vecs[12] = '{1'b1, 1'b1, 6'd4,  32'h0000_0111, 32'h0000_0404};
    vecs[13] = '{1'b0, 1'b1, 6'd4,  32'h0,         32'h0000_0111};
    vecs[14] = '{1'b1, 1'b0, 6'd3,  32'h0002_0002, 32'h0};
    vecs[15] = '{1'b0, 1'b1, 6'd3,  32'h0,         32'h0002_0002};
    vecs[16] = '{1'b0, 1'b1, 6'd8,  32'h0,         32'h0};
    vecs[17] = '{1'b0, 1'b1, 6'd63, 32'h0,         32'h0};
    vecs[18] = '{1'b0, 1'b1, 6'd7,  32'h0,         32'h9745_BF27};
    vecs[19] = '{1'b1, 1'b0, 6'd63, 32'h0000_0001, 32'h0};

    for (int i = 0; i < 20; i++)
      applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].expRd,
                    $sformatf("vec%0d", i));
    checkOutput("readdata_hold", mgmt_readdata, 32'h9745_BF27);
    checkOutput("idle_cfg_n", cfg_n, 32'h0001_0000);
    checkOutput("idle_cfg_m", cfg_m, 32'h0000_0404);
    checkOutput("idle_cfg_c0", cfg_c0, 32'h0000_0505);

    // Full reconfiguration in waitrequest mode, lock arriving 10 cycles after areset drops.
    applyStimulus(1'b1, 1'b0, 6'd5, 32'h0002_0504, 32'h0, "wr_c0");
    applyStimulus(1'b1, 1'b0, 6'd7, 32'hA3D7_09E8, 32'h0, "wr_frac");
    startReconf();
    arCycles = 0; doneCnt = 0; stallBad = 0; sinceFall = -1; prevAr = 1'b0; sawDone = 1'b0;
    for (int cyc = 1; cyc <= 300 && !sawDone; cyc++) begin
      @(negedge mgmt_clk);
      if (cyc == 1) begin
        checkOutput("apply_cfg_c0", cfg_c0, 32'h0002_0504);
        checkOutput("apply_cfg_frac", cfg_frac, 32'hA3D7_09E8);
        checkOutput("apply_cfg_n", cfg_n, 32'h0002_0002);
        checkOutput("apply_cfg_m", cfg_m, 32'h0000_0111);
        checkOutput("apply_areset", pll_areset, 32'h0);
      end
      if (mgmt_waitrequest !== 1'b1) stallBad++;
      if (pll_areset) arCycles++;
      if (prevAr && !pll_areset) sinceFall = 0;
      else if (sinceFall >= 0) sinceFall++;
      if (sinceFall == 10) pll_locked = 1'b1;
      prevAr = pll_areset;
      if (reconf_done) begin
        doneCnt++;
        sawDone = 1'b1;
      end
    end
    checkOutput("reconf_done_seen", sawDone, 32'h1);
    checkOutput("areset_cycles", arCycles, 32'd16);
    checkOutput("busy_waitrequest_low_cycles", stallBad, 32'd0);
    @(negedge mgmt_clk);
    checkOutput("waitrequest_after_done", mgmt_waitrequest, 32'h0);
    checkOutput("done_single_pulse", reconf_done, 32'h0);
    checkOutput("done_pulse_count", doneCnt, 32'd1);

    // A write issued while busy must stall until the block is idle again.
    startReconf();
    mgmt_write = 1'b1; mgmt_address = 6'd4; mgmt_writedata = 32'h0000_0777;
    stalled = 0; sawIdle = 1'b0;
    for (int cyc = 0; cyc < 100 && !sawIdle; cyc++) begin
      @(negedge mgmt_clk);
      if (mgmt_waitrequest) stalled++;
      else sawIdle = 1'b1;
    end
    @(posedge mgmt_clk);
    #1;
    mgmt_write = 1'b0;
    checkOutput("stall_cycles", stalled, 32'd19);
    checkOutput("stall_cfg_m", cfg_m, 32'h0000_0111);
    applyStimulus(1'b0, 1'b1, 6'd4, 32'h0, 32'h0000_0777, "m_after_stall");

    // Lock never arrives: timeout sets the sticky error bit.
    pll_locked = 1'b0;
    startReconf();
    doneCycle = 0;
    for (int cyc = 1; cyc <= 5000 && doneCycle == 0; cyc++) begin
      @(negedge mgmt_clk);
      if (reconf_done) doneCycle = cyc;
    end
    checkOutput("timeout_done_cycle", doneCycle, 32'd4114);
    checkOutput("timeout_cfg_m", cfg_m, 32'h0000_0777);
    applyStimulus(1'b0, 1'b1, 6'd1, 32'h0, 32'h0000_0002, "status_err_set");
    applyStimulus(1'b1, 1'b0, 6'd1, 32'h0, 32'h0, "clear_err");
    applyStimulus(1'b0, 1'b1, 6'd1, 32'h0, 32'h0000_0000, "status_err_clear");

    // Polling mode: requests serviced while busy, second START ignored.
    applyStimulus(1'b1, 1'b0, 6'd0, 32'h1, 32'h0, "mode_poll");
    applyStimulus(1'b0, 1'b1, 6'd0, 32'h0, 32'h1, "mode_read");
    startReconf();
    applyStimulus(1'b0, 1'b1, 6'd1, 32'h0, 32'h0000_0001, "poll_status_busy");
    checkOutput("poll_waitrequest", mgmt_waitrequest, 32'h0);
    applyStimulus(1'b1, 1'b0, 6'd2, 32'h1, 32'h0, "poll_start_again");
    applyStimulus(1'b1, 1'b0, 6'd3, 32'h0003_0003, 32'h0, "poll_wr_n");
    applyStimulus(1'b0, 1'b1, 6'd3, 32'h0, 32'h0003_0003, "poll_rd_n");
    pll_locked = 1'b1;
    doneCnt = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge mgmt_clk);
      if (reconf_done) doneCnt++;
    end
    checkOutput("poll_done_count", doneCnt, 32'd1);
    checkOutput("poll_cfg_n", cfg_n, 32'h0002_0002);
    applyStimulus(1'b0, 1'b1, 6'd1, 32'h0, 32'h0000_0004, "poll_status_idle");

    // Reset in the middle of the areset pulse.
    pll_locked = 1'b0;
    startReconf();
    sawAreset = 1'b0;
    for (int cyc = 0; cyc < 20 && !sawAreset; cyc++) begin
      @(negedge mgmt_clk);
      if (pll_areset) sawAreset = 1'b1;
    end
    checkOutput("midrst_areset_seen", sawAreset, 32'h1);
    repeat (3) @(negedge mgmt_clk);
    mgmt_reset = 1'b1;
    @(negedge mgmt_clk);
    checkOutput("midrst_areset", pll_areset, 32'h0);
    checkOutput("midrst_waitrequest", mgmt_waitrequest, 32'h0);
    checkOutput("midrst_done", reconf_done, 32'h0);
    checkOutput("midrst_readdata", mgmt_readdata, 32'h0);
    checkOutput("midrst_cfg_n", cfg_n, 32'h0001_0000);
    checkOutput("midrst_cfg_m", cfg_m, 32'h0000_0404);
    checkOutput("midrst_cfg_c0", cfg_c0, 32'h0000_0505);
    checkOutput("midrst_cfg_frac", cfg_frac, 32'h9745_BF27);
    mgmt_reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 6'd1, 32'h0, 32'h0, "midrst_status");
    applyStimulus(1'b0, 1'b1, 6'd0, 32'h0, 32'h0, "midrst_mode");
    applyStimulus(1'b0, 1'b1, 6'd5, 32'h0, 32'h0000_0505, "midrst_c0_shadow");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_mgmt_responder.md
PLL_MGMT_RESPONDER -- requirements
Module: pll_mgmt_responder

Interface
REQ-001 The block SHALL have parameter RESET_CYCLES, default 16, giving the pll_areset pulse length in mgmt_clk cycles.
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 4096, giving the maximum number of mgmt_clk cycles to wait for lock after pll_areset.
REQ-003 Port mgmt_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port mgmt_reset, input, 1 bit: synchronous reset, active-high.
REQ-005 Port mgmt_address, input, 6 bits: register address.
REQ-006 Port mgmt_write, input, 1 bit: write request.
REQ-007 Port mgmt_writedata, input, 32 bits: write data.
REQ-008 Port mgmt_read, input, 1 bit: read request.
REQ-009 Port mgmt_readdata, output, 32 bits: read data, registered.
REQ-010 Port mgmt_waitrequest, output, 1 bit: stall; a request is accepted only in a cycle where this is 0.
REQ-011 Port pll_locked, input, 1 bit: lock indication from the PLL.
REQ-012 Port pll_areset, output, 1 bit: PLL reset.
REQ-013 Ports cfg_n, cfg_m, cfg_c0 and cfg_frac, outputs, 32 bits each: active N, M, C0 and M-fraction settings.
REQ-014 Port reconf_done, output, 1 bit: one-cycle pulse when a reconfiguration finishes.

Function
REQ-015 Register map SHALL be:
- 0: MODE; bit0 = 0 waitrequest mode, 1 polling mode.
- 1: STATUS; bit0 busy, bit1 timeout error (sticky), bit2 pll_locked live.
- 2: START; any write starts a reconfiguration.
- 3: N shadow.
- 4: M shadow.
- 5: C shadow.
- 7: FRAC shadow.
REQ-016 A write SHALL be accepted when mgmt_write=1 and mgmt_waitrequest=0, and SHALL update the target register at that clock edge.
REQ-017 Writes to unmapped addresses (6, 8-63) SHALL be ignored; reads from them SHALL return 0.
REQ-018 A write to address 5 SHALL update the C0 shadow only if writedata[22:18]=0; any other value in that field SHALL be ignored.
REQ-019 A write to address 1 SHALL clear the timeout error bit; no other bits are affected.
REQ-020 A read SHALL be accepted when mgmt_read=1 and mgmt_waitrequest=0; mgmt_readdata SHALL present the register value one cycle later and hold it until the next accepted read.
REQ-021 Reads of addresses 0, 3, 4, 5 and 7 SHALL return the shadow value, or the MODE register for address 0.
REQ-022 If write and read are asserted in the same cycle, the write SHALL take effect and the read SHALL return the pre-write value.
REQ-023 The state machine SHALL have states IDLE, APPLY, RST, LOCKWAIT and DONE.
REQ-024 IDLE->APPLY SHALL occur on an accepted START write.
REQ-025 APPLY SHALL last 1 cycle, copy all shadows to the cfg_* outputs, then go to RST.
REQ-026 RST SHALL hold pll_areset=1 for exactly RESET_CYCLES cycles, then go to LOCKWAIT.
REQ-027 LOCKWAIT SHALL go to DONE on the first cycle pll_locked=1. If pll_locked stays 0 for LOCK_TIMEOUT cycles, it SHALL set the timeout error bit and go to DONE.
REQ-028 DONE SHALL last 1 cycle, assert reconf_done, then return to IDLE.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 In waitrequest mode, mgmt_waitrequest SHALL equal busy (combinational from the state register), so every request stalls until IDLE.
REQ-031 In polling mode, mgmt_waitrequest SHALL be 0 at all times.
REQ-032 In polling mode, STATUS reads SHALL be serviced during busy.
REQ-033 In polling mode, writes during busy SHALL update shadows only; a START write during busy SHALL be ignored.
REQ-034 cfg_* outputs SHALL change only in APPLY or on reset.
REQ-035 Shadow writes in IDLE SHALL NOT affect the cfg_* outputs until the next START.
REQ-036 The lock-wait counter SHALL be wide enough for LOCK_TIMEOUT without wrap and SHALL restart from 0 on each LOCKWAIT entry.

Reset
REQ-037 While mgmt_reset=1, regardless of current state, the block SHALL enter IDLE.
REQ-038 On reset, mgmt_waitrequest, pll_areset, reconf_done and mgmt_readdata SHALL be 0; MODE and error bit SHALL be 0.
REQ-039 On reset, shadows and cfg_* outputs SHALL load these defaults: N=32'h00010000, M=32'h00000404, C0=32'h00000505, FRAC=32'h9745BF27.
REQ-040 A reset during RST SHALL drop pll_areset to 0 at the next edge.

Verification
REQ-041 After reset, read addresses 3, 4, 5, 7 -> 00010000, 00000404, 00000505, 9745BF27; cfg_* equal the same values.
REQ-042 In waitrequest mode, write C0=00020504, FRAC=A3D709E8, then START, with pll_locked rising 10 cycles after pll_areset falls:
- pll_areset high for exactly 16 cycles;
- cfg_c0=00020504 from the APPLY cycle;
- reconf_done pulses once;
- waitrequest is high from the cycle after START until the cycle after DONE.
REQ-043 Issue a write to address 4 during busy in waitrequest mode -> it stalls; M shadow updates only once the block returns to IDLE.
REQ-044 Hold pll_locked=0 after START -> STATUS bit1=1 after 16+4096 cycles, reconf_done pulses; a write to address 1 clears the bit.
REQ-045 In polling mode, STATUS reads during busy return bit0=1 with waitrequest 0; a second START during busy is ignored (a single reconf_done pulse).
REQ-046 Assert mgmt_reset mid-RST -> next cycle state is IDLE, pll_areset=0, and cfg_* hold the REQ-039 defaults.
